// File: rtl/div_iter.sv
// rtl/div_iter.sv - radix-2 restoring iterative divider for the EX stage (DIV/DIVU)
//
// Computes quotient and remainder one quotient bit per cycle. While a divide is
// in flight busy_o requests a pipeline stall; on completion {remainder, quotient}
// is presented for the HI/LO write path.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = two's-complement divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until ready_o is seen
//   annul_i       abort the current or pending operation
//   result_o      {remainder, quotient}, zero unless ready_o = 1
//   ready_o       result valid
//   busy_o        stall request to pipeline control
module div_iter #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   dvd;       // dividend magnitude, quotient bits shift in at the LSB
  logic [WIDTH-1:0]   dsr;       // divisor magnitude
  logic [WIDTH-1:0]   rem;       // partial remainder
  logic               neg_q;
  logic               neg_r;
  logic [2*WIDTH-1:0] result_r;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;

  always_comb begin
    a_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    b_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Shifted partial remainder is WIDTH+1 bits; since rem < dsr, a negative
    // trial difference always fits in WIDTH+1 bits and its MSB is the borrow.
    diff     = {rem, dvd[WIDTH-1]} - {1'b0, dsr};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
    quo_next = {dvd[WIDTH-2:0], q_bit};

    // Most-negative / -1 wraps naturally: magnitude 0x80..0 negated is itself.
    quo_fix  = neg_q ? -quo_next : quo_next;
    rem_fix  = neg_r ? -rem_next : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_r <= '0;
    end else begin
      case (state)
        FREE: begin
          // Operands are captured every idle cycle; the copy taken on the
          // edge that accepts start_i is the one the divide uses.
          cnt   <= '0;
          rem   <= '0;
          dvd   <= a_mag;
          dsr   <= b_mag;
          neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_r <= signed_div_i & opdata1_i[WIDTH-1];
          if (!annul_i && start_i) begin
            state <= (opdata2_i == '0) ? BY_ZERO : ON;
          end
        end
        BY_ZERO: begin
          result_r <= '0;
          state    <= END;
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else begin
            rem <= rem_next;
            dvd <= quo_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) begin
              result_r <= {rem_fix, quo_fix};
              state    <= END;
            end
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            state <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  assign ready_o  = (state == END);
  assign result_o = ready_o ? result_r : '0;
  assign busy_o   = (state == ON) || (state == BY_ZERO) ||
                    ((state == FREE) && start_i && !annul_i);

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter (WIDTH=32 and WIDTH=8)
module tb_div_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        sgn32, start32, annul32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        rdy32, busy32;

  logic        sgn8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8, busy8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb32[$];
  logic [15:0] sb8[$];

  div_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sgn32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(rdy32), .busy_o(busy32)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8), .busy_o(busy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Drives one divide on the 32-bit instance, expected value pushed at stimulus.
  task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string name);
    int n;
    int busy_bad;
    logic [63:0] want;
    int lat;
    lat = (b == 32'd0) ? 1 : 32;
    sb32.push_back(exp);
    sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
    #1;
    n_checks++;
    if (busy32 !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_at_request: got %b want 1", name, busy32);
    end
    tick();
    n = 0; busy_bad = 0;
    while (rdy32 !== 1'b1 && n < 80) begin
      if (busy32 !== 1'b1) busy_bad++;
      tick();
      n++;
    end
    n_checks++;
    if (rdy32 !== 1'b1 || n != lat) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d (ready=%b)", name, n, lat, rdy32);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++; $display("FAIL %s busy_during_divide: %0d low cycles, want 0", name, busy_bad);
    end
    n_checks++;
    if (busy32 !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_at_ready: got %b want 0", name, busy32);
    end
    want = sb32.pop_front();
    n_checks++;
    if (res32 !== want) begin
      n_fail++; $display("FAIL %s result: got %h want %h", name, res32, want);
    end
    // still held in END while start stays high
    tick();
    n_checks++;
    if (rdy32 !== 1'b1 || res32 !== want) begin
      n_fail++; $display("FAIL %s hold: ready=%b result=%h want 1 %h", name, rdy32, res32, want);
    end
    start32 = 1'b0;
    tick();
    n_checks++;
    if (rdy32 !== 1'b0 || res32 !== 64'd0 || busy32 !== 1'b0) begin
      n_fail++; $display("FAIL %s release: ready=%b result=%h busy=%b want 0 0 0", name, rdy32, res32, busy32);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string name);
    int n;
    logic [15:0] want;
    sb8.push_back(exp);
    sgn8 = 1'b0; a8 = a; b8 = b; start8 = 1'b1;
    tick();
    n = 0;
    while (rdy8 !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    n_checks++;
    if (rdy8 !== 1'b1 || n != 8) begin
      n_fail++; $display("FAIL %s latency: got %0d want 8 (ready=%b)", name, n, rdy8);
    end
    want = sb8.pop_front();
    n_checks++;
    if (res8 !== want || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL %s result: got %h busy=%b want %h busy=0", name, res8, busy8, want);
    end
    start8 = 1'b0;
    tick();
    n_checks++;
    if (rdy8 !== 1'b0) begin
      n_fail++; $display("FAIL %s release: ready=%b want 0", name, rdy8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (rdy32 !== 1'b0 || busy32 !== 1'b0 || res32 !== 64'd0) begin
      n_fail++; $display("FAIL reset32: ready=%b busy=%b result=%h want 0 0 0", rdy32, busy32, res32);
    end
    n_checks++;
    if (rdy8 !== 1'b0 || busy8 !== 1'b0 || res8 !== 16'd0) begin
      n_fail++; $display("FAIL reset8: ready=%b busy=%b result=%h want 0 0 0", rdy8, busy8, res8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    run32(1'b0, 32'd7, 32'd2, {32'h0000_0001, 32'h0000_0003}, "u7div2");
  endtask

  task automatic test_signed();
    run32(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s-7div2");
    run32(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, "s7div-2");
    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "s_min_div_m1");
    run32(1'b1, 32'd0, 32'hFFFF_FFFB, 64'd0, "s0div-5");
  endtask

  task automatic test_div_zero();
    run32(1'b0, 32'd1234, 32'd0, 64'd0, "u_divzero");
    run32(1'b1, 32'hFFFF_0000, 32'd0, 64'd0, "s_divzero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd3;
      run32(s, a, b, model32(s, a, b), "random");
    end
  endtask

  task automatic abort_check(input string name);
    int seen;
    n_checks++;
    if (busy32 !== 1'b0 || rdy32 !== 1'b0) begin
      n_fail++; $display("FAIL %s after_abort: busy=%b ready=%b want 0 0", name, busy32, rdy32);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rdy32 !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL %s ready_after_abort: %0d cycles high, want 0", name, seen);
    end
  endtask

  task automatic test_annul();
    sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    tick();
    repeat (10) tick();
    annul32 = 1'b1; start32 = 1'b0;
    tick();
    annul32 = 1'b0;
    abort_check("annul");
  endtask

  task automatic test_rst_mid();
    sgn32 = 1'b1; a32 = 32'hFFFF_F000; b32 = 32'd5; start32 = 1'b1;
    tick();
    repeat (10) tick();
    rst = 1'b1; start32 = 1'b0;
    tick();
    rst = 1'b0;
    abort_check("rst_mid");
  endtask

  task automatic test_back_to_back();
    run32(1'b0, 32'd100, 32'd9, {32'd1, 32'd11}, "b2b_a");
    run32(1'b0, 32'hFFFF_FFFF, 32'd16, {32'd15, 32'h0FFF_FFFF}, "b2b_b");
    run8(8'd200, 8'd7, {8'h04, 8'h1C}, "w8_200div7");
    run8(8'd255, 8'd16, {8'h0F, 8'h0F}, "w8_b2b");
  endtask

  initial begin
    rst = 1'b1;
    sgn32 = 1'b0; start32 = 1'b0; annul32 = 1'b0; a32 = '0; b32 = '0;
    sgn8 = 1'b0; start8 = 1'b0; annul8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_random();
    test_annul();
    test_rst_mid();
    test_back_to_back();
    n_checks++;
    if (sb32.size() != 0 || sb8.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d/%0d left, want 0", sb32.size(), sb8.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative divider serving the EX stage of the five-stage MIPS pipeline. It computes signed or unsigned quotient and remainder for DIV/DIVU by radix-2 restoring division, one quotient bit per cycle. While it runs it raises a stall request, so the pipeline holds the dividing instruction in EX. On completion it presents {remainder, quotient} for the HI/LO write path (HI = remainder, LO = quotient).

## Interface
- WIDTH, 32, operand width in bits; legal range ≥ 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; held high by EX until ready_o is seen.
- annul_i  in  1  abort the current or pending operation (branch-delay or flush cancel).
- result_o  out  2*WIDTH  {remainder, quotient}; valid only while ready_o = 1.
- ready_o  out  1  result valid.
- busy_o  out  1  stall request to the pipeline control.

## Operation
- States: FREE, BY_ZERO, ON, END.
- FREE
  - annul_i = 1: stay in FREE. annul_i has priority over start_i.
  - start_i = 1 and opdata2_i = 0: go to BY_ZERO.
  - start_i = 1 otherwise: go to ON.
  - On the sampling edge, latch the operands and signed_div_i, and clear the counter.
- Signed mode
  - Magnitudes are taken at latch: |x| = two's negate when the MSB is set.
  - Unsigned mode uses the operands as-is.
- ON: one restoring step per cycle.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude over WIDTH+1 bits.
  - If the result is non-negative, keep it and set quotient bit = 1; otherwise quotient bit = 0.
  - The counter increments every step.
- Last step (counter = WIDTH-1), on the same edge:
  - Apply sign fix-up and register the final result.
  - Go to END.
- Sign fix-up, signed mode only:
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Arithmetic edge cases:
  - Signed 0x80..0 / all-ones gives quotient 0x80..0 (wraps) and remainder 0.
  - Dividend 0 gives quotient 0 and remainder 0.
- BY_ZERO: result = 0 (quotient and remainder). Go to END on the next edge.
- ON, annul_i = 1: go to FREE immediately. The partial result is discarded and ready_o never rises.
- END
  - ready_o = 1, result_o holds the value.
  - start_i = 0: go to FREE.
  - annul_i = 1: go to FREE.
  - start_i still 1: stay in END, result held.
- A new start_i can only be sampled from FREE. Back-to-back divides therefore need one FREE cycle in between.
- busy_o = 1 in ON and BY_ZERO, and in FREE when start_i = 1 and annul_i = 0 (combinational). Otherwise 0.
- result_o = 0 whenever ready_o = 0.

## Timing
- Reset (rst high at an edge): state FREE, counter 0, result register 0, ready_o 0, busy_o 0 (given start_i = 0).
- rst has priority over all inputs, including mid-division; no result is produced after it.
- Let E0 be the edge at which FREE samples start_i.
- Normal divide: ON steps at E1..E_WIDTH. ready_o is high from E_WIDTH, i.e. WIDTH cycles after E0.
- Divide by zero: BY_ZERO at E0, END at E1. ready_o is high from E1.
- busy_o cycle-by-cycle:
  - High from the cycle start_i is first seen in FREE.
  - Falls in the same cycle ready_o rises.
  - Falls in the cycle after annul_i is sampled in ON.
- Outputs depend only on registered state, except busy_o.

## Test plan
- WIDTH=32, unsigned 7/2, start held: ready_o rises 32 cycles after E0. result_o = {0x00000001, 0x00000003}. busy_o drops the same cycle.
- WIDTH=32, signed -7/2 (0xFFFFFFF9 / 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2: quotient 0xFFFFFFFD, remainder 0x00000001.
- WIDTH=32, divisor 0: ready_o at E1 with result_o = 0. Then start_i dropped: FREE and ready_o = 0 next cycle.
- WIDTH=32, signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- annul_i pulsed at step 10 of a divide: FREE next edge, busy_o = 0, and ready_o stays 0 for the following 40 cycles. rst asserted mid-divide: same outcome.
- WIDTH=8, unsigned 200/7: ready_o 8 cycles after E0, result_o = {0x04, 0x1C}. Two back-to-back divides succeed with one FREE cycle between them.
